// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : UART (8N1) program-image loader. Writes a 16-byte frame into CPU
//            RAM and releases the CPU only after the checksum verifies.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       prog,
  output logic [3:0] addr,
  output logic [7:0] programm_input,
  output logic       cpu_reset,
  output logic       loaded,
  output logic       error
);

  localparam int             c_CW   = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] c_RX_IDLE  = 2'd0;
  localparam logic [1:0] c_RX_START = 2'd1;
  localparam logic [1:0] c_RX_DATA  = 2'd2;
  localparam logic [1:0] c_RX_STOP  = 2'd3;

  localparam logic [1:0] c_WAIT_SYNC = 2'd0;
  localparam logic [1:0] c_LOAD      = 2'd1;
  localparam logic [1:0] c_CHECK     = 2'd2;
  localparam logic [1:0] c_RUN       = 2'd3;

  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]      r_rx_state, w_rx_state_n;
  logic [c_CW-1:0] r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_shift;
  logic            w_byte_valid, w_frame_err;

  logic [1:0] r_state, w_state_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic [7:0] r_sum, w_sum_n;
  logic       r_prog, w_prog_n;
  logic [3:0] r_addr, w_addr_n;
  logic [7:0] r_data, w_data_n;
  logic       r_cpu_reset, w_cpu_reset_n;
  logic       r_loaded, w_loaded_n;
  logic       r_error, w_error_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Stop-bit sample cycle: these strobes are the receiver's byte/framing events
  assign w_byte_valid = (r_rx_state == c_RX_STOP) && (r_rx_cnt == c_FULL) && r_rx_sync;
  assign w_frame_err  = (r_rx_state == c_RX_STOP) && (r_rx_cnt == c_FULL) && !r_rx_sync;

  always_ff @(posedge clk) begin
    if (reset) r_rx_state <= c_RX_IDLE;
    else       r_rx_state <= w_rx_state_n;
  end

  always_comb begin
    w_rx_state_n = r_rx_state;
    case (r_rx_state)
      c_RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_state_n = c_RX_START;
      c_RX_START: if (r_rx_cnt == c_HALF) w_rx_state_n = r_rx_sync ? c_RX_IDLE : c_RX_DATA;
      c_RX_DATA:  if (r_rx_cnt == c_FULL && r_rx_bit == 3'd7) w_rx_state_n = c_RX_STOP;
      default:    if (r_rx_cnt == c_FULL) w_rx_state_n = c_RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_cnt <= '0;
      r_rx_bit <= 3'd0;
      r_shift  <= 8'h00;
    end else begin
      case (r_rx_state)
        c_RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= 3'd0;
        end
        c_RX_START: r_rx_cnt <= (r_rx_cnt == c_HALF) ? '0 : r_rx_cnt + 1'b1;
        c_RX_DATA: begin
          if (r_rx_cnt == c_FULL) begin
            r_rx_cnt <= '0;
            r_rx_bit <= r_rx_bit + 3'd1;
            r_shift  <= {r_rx_sync, r_shift[7:1]};
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_cnt <= (r_rx_cnt == c_FULL) ? '0 : r_rx_cnt + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_WAIT_SYNC;
      r_cnt       <= 4'd0;
      r_sum       <= 8'h00;
      r_prog      <= 1'b0;
      r_addr      <= 4'd0;
      r_data      <= 8'h00;
      r_cpu_reset <= 1'b1;
      r_loaded    <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_sum       <= w_sum_n;
      r_prog      <= w_prog_n;
      r_addr      <= w_addr_n;
      r_data      <= w_data_n;
      r_cpu_reset <= w_cpu_reset_n;
      r_loaded    <= w_loaded_n;
      r_error     <= w_error_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (w_frame_err) begin
      w_state_n = c_WAIT_SYNC;
    end else if (w_byte_valid) begin
      case (r_state)
        c_WAIT_SYNC, c_RUN: if (r_shift == SYNC_BYTE) w_state_n = c_LOAD;
        c_LOAD:             if (r_cnt == 4'd15) w_state_n = c_CHECK;
        default:            w_state_n = (r_shift == r_sum) ? c_RUN : c_WAIT_SYNC;
      endcase
    end
  end

  always_comb begin
    w_prog_n      = 1'b0;
    w_addr_n      = r_addr;
    w_data_n      = r_data;
    w_cpu_reset_n = r_cpu_reset;
    w_loaded_n    = r_loaded;
    w_error_n     = r_error;
    w_cnt_n       = r_cnt;
    w_sum_n       = r_sum;
    if (w_frame_err) begin
      w_error_n = 1'b1;
    end else if (w_byte_valid) begin
      case (r_state)
        c_WAIT_SYNC, c_RUN: begin
          if (r_shift == SYNC_BYTE) begin
            w_error_n     = 1'b0;
            w_cnt_n       = 4'd0;
            w_sum_n       = 8'h00;
            w_cpu_reset_n = 1'b1;
            w_loaded_n    = 1'b0;
          end
        end
        c_LOAD: begin
          w_prog_n = 1'b1;
          w_addr_n = r_cnt;
          w_data_n = r_shift;
          w_sum_n  = r_sum + r_shift;
          w_cnt_n  = r_cnt + 4'd1;
        end
        default: begin
          if (r_shift == r_sum) begin
            w_cpu_reset_n = 1'b0;
            w_loaded_n    = 1'b1;
          end else begin
            w_error_n = 1'b1;
          end
        end
      endcase
    end
  end

  assign prog           = r_prog;
  assign addr           = r_addr;
  assign programm_input = r_data;
  assign cpu_reset      = r_cpu_reset;
  assign loaded         = r_loaded;
  assign error          = r_error;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Directed self-checking bench for prog_loader with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       prog;
  logic [3:0] addr;
  logic [7:0] programm_input;
  logic       cpu_reset;
  logic       loaded;
  logic       error;

  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  int          addr0_cyc = -1;
  int          t0;
  logic [11:0] sb[$];
  logic [11:0] exp_w;

  prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx(rx), .prog(prog), .addr(addr),
    .programm_input(programm_input), .cpu_reset(cpu_reset),
    .loaded(loaded), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  // Data bytes are pushed to the scoreboard as they are driven
  task automatic send_frame(input logic with_sync, input logic [7:0] base, input logic [7:0] cks);
    if (with_sync) send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) begin
      sb.push_back({4'(i), base + 8'(i)});
      if (i == 0) t0 = cyc;
      send_byte(base + 8'(i), 1'b1);
    end
    send_byte(cks, 1'b1);
  endtask

  always @(negedge clk) begin
    if (prog) begin
      check("prog_with_cpu_running", {31'd0, cpu_reset}, 32'd1);
      n_total++;
      assert (sb.size() != 0) n_pass++;
      else $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", addr, programm_input);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("write_addr_data", {20'd0, addr, programm_input}, {20'd0, exp_w});
      end
      if (addr == 4'd0) addr0_cyc = cyc;
    end
  end

  initial begin
    tick(1);
    for (int i = 0; i < 3; i++) begin
      check("rst_prog", {31'd0, prog}, 32'd0);
      check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("rst_loaded_error", {30'd0, loaded, error}, 32'd0);
      tick(1);
    end
    check("rst_addr_data", {20'd0, addr, programm_input}, 32'd0);
    reset = 1'b0;
    tick(5);

    send_frame(1'b1, 8'h10, 8'h78);
    check("good_cpu_reset_before_edge", {31'd0, cpu_reset}, 32'd1);
    tick(1);
    check("good_cpu_reset_falls", {31'd0, cpu_reset}, 32'd0);
    check("good_loaded", {31'd0, loaded}, 32'd1);
    check("good_error", {31'd0, error}, 32'd0);
    check("latency_start_to_prog", addr0_cyc - t0, 32'(2 + CPB / 2 + 9 * CPB + 1));
    check("addr_data_hold", {20'd0, addr, programm_input}, {20'd0, 4'hF, 8'h1F});
    check("sb_drained_good", sb.size(), 32'd0);

    send_byte(8'h00, 1'b1);
    tick(3);
    check("run_ignore_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("run_ignore_loaded", {31'd0, loaded}, 32'd1);
    send_byte(8'hA5, 1'b1);
    check("run_sync_before_edge", {31'd0, cpu_reset}, 32'd0);
    tick(1);
    check("run_sync_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("run_sync_loaded", {31'd0, loaded}, 32'd0);

    send_frame(1'b0, 8'h10, 8'h77);
    tick(2);
    check("badcks_error", {31'd0, error}, 32'd1);
    check("badcks_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("badcks_loaded", {31'd0, loaded}, 32'd0);
    check("sb_drained_badcks", sb.size(), 32'd0);

    send_byte(8'hA5, 1'b1);
    tick(2);
    check("sync_clears_error", {31'd0, error}, 32'd0);
    send_frame(1'b0, 8'h10, 8'h78);
    tick(2);
    check("recover_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("recover_loaded", {31'd0, loaded}, 32'd1);

    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    check("glitch_state", {29'd0, cpu_reset, loaded, error}, 32'b010);
    check("sb_drained_glitch", sb.size(), 32'd0);

    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sb.push_back({4'(i), 8'h20 + 8'(i)});
      send_byte(8'h20 + 8'(i), 1'b1);
    end
    send_byte(8'h3C, 1'b0);
    tick(2);
    check("frame_err_error", {31'd0, error}, 32'd1);
    for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 1'b1);
    tick(4);
    check("frame_err_sticky", {31'd0, error}, 32'd1);
    check("frame_err_addr_hold", {28'd0, addr}, 32'd4);
    check("sb_drained_frame_err", sb.size(), 32'd0);

    send_frame(1'b1, 8'h10, 8'h78);
    tick(2);
    check("after_ferr_good", {29'd0, cpu_reset, loaded, error}, 32'b010);

    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 7; i++) begin
      sb.push_back({4'(i), 8'hC0 + 8'(i)});
      send_byte(8'hC0 + 8'(i), 1'b1);
    end
    rx = 1'b0;
    tick(12);
    check("pre_reset_addr", {28'd0, addr}, 32'd6);
    reset = 1'b1;
    tick(1);
    check("midrst_prog", {31'd0, prog}, 32'd0);
    check("midrst_addr_data", {20'd0, addr, programm_input}, 32'd0);
    check("midrst_flags", {29'd0, cpu_reset, loaded, error}, 32'b100);
    reset = 1'b0;
    rx = 1'b1;
    tick(10);
    send_byte(8'h55, 1'b1);
    tick(4);
    check("post_rst_wait_sync", {29'd0, cpu_reset, loaded, error}, 32'b100);
    check("sb_drained_final", sb.size(), 32'd0);

    send_frame(1'b1, 8'h10, 8'h78);
    tick(2);
    check("final_run", {29'd0, cpu_reset, loaded, error}, 32'b010);
    check("sb_drained_end", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
